// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame geometry and counter sizing.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } uart_state_t;

    // Width of a down-counter that must hold values up to cycles_per_bit-1.
    function automatic int uart_cnt_width(input int cycles_per_bit);
        return (cycles_per_bit > 1) ? $clog2(cycles_per_bit) : 1;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Metastability synchroniser for an asynchronous idle-high line; resets to 1
// so a line held in reset does not look like a start bit on release.
module uart_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic m_aresetn,
    input  logic line,
    output logic synced
);

    generate
        if (SYNC_STAGES < 2) begin : g_stage_check
            $error("uart_sync: SYNC_STAGES must be >= 2");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] stages;

    always_ff @(posedge clk or negedge m_aresetn) begin
        if (!m_aresetn) begin
            stages <= '1;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], line};
        end
    end

    assign synced = stages[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, a single-entry holding register,
// and framing-error / line-break / overrun reporting.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CYCLES_PER_BIT = 434,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                      clk,
    input  logic                      m_aresetn,
    input  logic                      uart_rxd,
    output logic                      rx_valid,
    output logic [UART_DATA_BITS-1:0] rx_data,
    input  logic                      rx_ready,
    output logic                      frame_err,
    output logic                      rx_break,
    output logic                      overrun
);

    localparam int               CNT_W       = uart_cnt_width(CYCLES_PER_BIT);
    localparam int               HALF        = CYCLES_PER_BIT / 2;
    localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(HALF - 1);
    localparam logic [2:0]       LAST_BIT    = 3'(UART_DATA_BITS - 1);

    generate
        if (CYCLES_PER_BIT < 4) begin : g_cpb_check
            $error("uart_rx: CYCLES_PER_BIT must be >= 4");
        end
    endgenerate

    logic rxs;

    uart_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .m_aresetn(m_aresetn),
        .line     (uart_rxd),
        .synced   (rxs)
    );

    uart_state_t               state;
    logic [CNT_W-1:0]          cnt;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shift;
    logic                      tick;

    assign tick = (cnt == '0);

    // A completion in STOP overrides the consumer-side clear of rx_valid below.
    always_ff @(posedge clk or negedge m_aresetn) begin
        if (!m_aresetn) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_valid  <= 1'b0;
            rx_data   <= '0;
            frame_err <= 1'b0;
            rx_break  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rxs) begin
                        cnt   <= HALF_RELOAD;
                        state <= START;
                    end
                end

                START: begin
                    if (!tick) begin
                        cnt <= cnt - 1'b1;
                    end else if (rxs) begin
                        state <= IDLE;
                    end else begin
                        cnt     <= BIT_RELOAD;
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end

                DATA: begin
                    if (!tick) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        cnt     <= BIT_RELOAD;
                        shift   <= {rxs, shift[UART_DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == LAST_BIT) begin
                            state <= STOP;
                        end
                    end
                end

                STOP: begin
                    if (!tick) begin
                        cnt <= cnt - 1'b1;
                    end else if (rxs) begin
                        cnt   <= BIT_RELOAD;
                        state <= IDLE;
                        if (!rx_valid || rx_ready) begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else begin
                        cnt       <= BIT_RELOAD;
                        frame_err <= 1'b1;
                        rx_break  <= 1'b1;
                        state     <= BRK;
                    end
                end

                BRK: begin
                    if (rxs) begin
                        rx_break <= 1'b0;
                        state    <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are predicted at frame level when sent
// and a monitor checks each byte the receiver presents, plus pulse timing.
module tb_uart_rx;

    localparam int CPB       = 16;
    localparam int SYNC      = 2;
    localparam int HALF      = CPB / 2;
    // Edges from the cycle the start bit is driven to the stop-tick edge.
    localparam int FRAME_LAT = SYNC + 1 + HALF + 9 * CPB;

    logic       clk       = 1'b0;
    logic       m_aresetn = 1'b0;
    logic       uart_rxd  = 1'b1;
    logic       rx_ready  = 1'b0;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       frame_err;
    logic       rx_break;
    logic       overrun;

    uart_rx #(
        .CYCLES_PER_BIT(CPB),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .clk      (clk),
        .m_aresetn(m_aresetn),
        .uart_rxd (uart_rxd),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .rx_break (rx_break),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         exp_fe = 0;
    int         exp_ov = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         ready_mode = 0;
    bit         model_full = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic driveBit(input logic v, input int ncycles);
        uart_rxd = v;
        for (int k = 0; k < ncycles; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idleCycles(input int ncycles);
        driveBit(1'b1, ncycles);
    endtask

    // Predicts the frame's outcome from the holding-register rules, then drives it.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
        logic [9:0] frame;
        if (!stop_bit) begin
            exp_fe++;
        end else if (ready_mode == 0 && model_full) begin
            exp_ov++;
        end else begin
            exp_q.push_back(data);
            model_full = (ready_mode == 0);
        end
        frame = {stop_bit, data, 1'b0};
        for (int b = 0; b < 10; b++) begin
            driveBit(frame[b], CPB);
        end
    endtask

    task automatic waitNeg(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Consumer whose ready is rx_valid delayed by one cycle when enabled.
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 1) rx_ready = prev;
            prev = rx_valid;
        end
    end

    // Monitor: pops an expected byte each time a new byte is presented.
    logic       valid_q = 1'b0;
    logic       hs_q    = 1'b0;
    logic [7:0] data_q  = 8'h00;
    logic       fe_q    = 1'b0;
    logic       ov_q    = 1'b0;

    always @(negedge clk) begin
        if (!m_aresetn) begin
            valid_q = 1'b0;
            hs_q    = 1'b0;
            fe_q    = 1'b0;
            ov_q    = 1'b0;
        end else begin
            if (rx_valid && (!valid_q || hs_q)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_byte: got 0x%0h expected none", rx_data);
                end else begin
                    checkOutput("rx_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
                end
            end else if (rx_valid && valid_q && !hs_q) begin
                checkOutput("rx_data_hold", {24'h0, rx_data}, {24'h0, data_q});
            end
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            checkOutput("frame_err_width", {31'h0, frame_err & fe_q}, 32'h0);
            checkOutput("overrun_width", {31'h0, overrun & ov_q}, 32'h0);
            valid_q = rx_valid;
            hs_q    = rx_valid && rx_ready;
            data_q  = rx_data;
            fe_q    = frame_err;
            ov_q    = overrun;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         t0;
        int         kind;
        int         gap;
        logic [7:0] d;
        logic [7:0] d77;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_rx_valid", {31'h0, rx_valid}, 32'h0);
        checkOutput("reset_rx_data", {24'h0, rx_data}, 32'h0);
        checkOutput("reset_frame_err", {31'h0, frame_err}, 32'h0);
        checkOutput("reset_rx_break", {31'h0, rx_break}, 32'h0);
        checkOutput("reset_overrun", {31'h0, overrun}, 32'h0);
        m_aresetn = 1'b1;
        idleCycles(4);

        $display("[TB] single frame with latency");
        ready_mode = 0;
        t0 = cyc;
        fork
            applyStimulus(8'hA5, 1'b1);
            begin
                waitNeg(t0 + FRAME_LAT - 1);
                checkOutput("t1_valid_early", {31'h0, rx_valid}, 32'h0);
                waitNeg(t0 + FRAME_LAT);
                checkOutput("t1_valid_on_time", {31'h0, rx_valid}, 32'h1);
                checkOutput("t1_data", {24'h0, rx_data}, 32'hA5);
            end
        join
        idleCycles(CPB);
        checkOutput("t1_frame_err_count", fe_cnt, exp_fe);
        checkOutput("t1_overrun_count", ov_cnt, exp_ov);
        ready_mode = 1;
        model_full = 1'b0;
        idleCycles(4);

        $display("[TB] glitch rejection");
        driveBit(1'b0, 4);
        idleCycles(2 * CPB);
        checkOutput("t2_no_byte_after_glitch", {31'h0, rx_valid}, 32'h0);
        applyStimulus(8'h3C, 1'b1);
        idleCycles(CPB);
        checkOutput("t2_pending", exp_q.size(), 0);
        checkOutput("t2_frame_err_count", fe_cnt, exp_fe);

        $display("[TB] framing error and break");
        t0 = cyc;
        fork
            applyStimulus(8'h3C, 1'b0);
            begin
                waitNeg(t0 + FRAME_LAT - 1);
                checkOutput("t3_break_early", {31'h0, rx_break}, 32'h0);
                checkOutput("t3_frame_err_early", {31'h0, frame_err}, 32'h0);
                waitNeg(t0 + FRAME_LAT);
                checkOutput("t3_break_set", {31'h0, rx_break}, 32'h1);
                checkOutput("t3_frame_err_pulse", {31'h0, frame_err}, 32'h1);
                waitNeg(t0 + FRAME_LAT + 1);
                checkOutput("t3_frame_err_cleared", {31'h0, frame_err}, 32'h0);
            end
        join
        driveBit(1'b0, 20 * CPB);
        checkOutput("t3_break_held", {31'h0, rx_break}, 32'h1);
        uart_rxd = 1'b1;
        t0 = cyc;
        waitNeg(t0 + SYNC);
        checkOutput("t3_break_until_sync", {31'h0, rx_break}, 32'h1);
        waitNeg(t0 + SYNC + 1);
        checkOutput("t3_break_released", {31'h0, rx_break}, 32'h0);
        @(posedge clk);
        #1;
        idleCycles(CPB);
        applyStimulus(8'h81, 1'b1);
        idleCycles(CPB);
        checkOutput("t3_frame_err_count", fe_cnt, exp_fe);
        checkOutput("t3_pending", exp_q.size(), 0);

        $display("[TB] overrun");
        ready_mode = 0;
        rx_ready   = 1'b0;
        model_full = 1'b0;
        idleCycles(4);
        applyStimulus(8'h11, 1'b1);
        t0 = cyc;
        fork
            applyStimulus(8'h22, 1'b1);
            begin
                waitNeg(t0 + FRAME_LAT - 1);
                checkOutput("t4_overrun_early", {31'h0, overrun}, 32'h0);
                waitNeg(t0 + FRAME_LAT);
                checkOutput("t4_overrun_pulse", {31'h0, overrun}, 32'h1);
                checkOutput("t4_data_kept", {24'h0, rx_data}, 32'h11);
                waitNeg(t0 + FRAME_LAT + 1);
                checkOutput("t4_overrun_cleared", {31'h0, overrun}, 32'h0);
            end
        join
        idleCycles(CPB);
        checkOutput("t4_valid_held", {31'h0, rx_valid}, 32'h1);
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready   = 1'b0;
        model_full = 1'b0;
        checkOutput("t4_valid_cleared", {31'h0, rx_valid}, 32'h0);
        checkOutput("t4_data_after_accept", {24'h0, rx_data}, 32'h11);
        checkOutput("t4_overrun_count", ov_cnt, exp_ov);

        $display("[TB] back-to-back with registered ready");
        ready_mode = 1;
        idleCycles(4);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'hFF, 1'b1);
        applyStimulus(8'h5A, 1'b1);
        idleCycles(2 * CPB);
        checkOutput("t5_pending", exp_q.size(), 0);
        checkOutput("t5_overrun_count", ov_cnt, exp_ov);

        $display("[TB] reset mid-frame");
        ready_mode = 0;
        rx_ready   = 1'b0;
        model_full = 1'b0;
        idleCycles(4);
        applyStimulus(8'h66, 1'b1);
        idleCycles(CPB);
        checkOutput("t6_held_before_reset", {31'h0, rx_valid}, 32'h1);
        d77 = 8'h77;
        driveBit(1'b0, CPB);
        for (int b = 0; b < 4; b++) driveBit(d77[b], CPB);
        driveBit(d77[4], HALF);
        m_aresetn = 1'b0;
        #1;
        checkOutput("t6_reset_rx_valid", {31'h0, rx_valid}, 32'h0);
        checkOutput("t6_reset_rx_data", {24'h0, rx_data}, 32'h0);
        checkOutput("t6_reset_frame_err", {31'h0, frame_err}, 32'h0);
        checkOutput("t6_reset_rx_break", {31'h0, rx_break}, 32'h0);
        checkOutput("t6_reset_overrun", {31'h0, overrun}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
        end
        #1;
        m_aresetn  = 1'b1;
        model_full = 1'b0;
        idleCycles(12 * CPB);
        applyStimulus(8'hC3, 1'b1);
        idleCycles(CPB);
        checkOutput("t6_valid_after", {31'h0, rx_valid}, 32'h1);
        checkOutput("t6_data_after", {24'h0, rx_data}, 32'hC3);
        ready_mode = 1;
        model_full = 1'b0;
        idleCycles(4);

        $display("[TB] randomized frames");
        for (int i = 0; i < 24; i++) begin
            kind = $urandom_range(0, 5);
            d    = 8'($urandom);
            gap  = $urandom_range(0, 2);
            if (kind == 0) begin
                driveBit(1'b0, $urandom_range(1, 5));
                idleCycles(2 * CPB);
            end
            applyStimulus(d, kind != 1);
            if (kind == 1) gap = gap + 1;
            idleCycles(gap * CPB);
        end
        idleCycles(4 * CPB);

        checkOutput("final_pending", exp_q.size(), 0);
        checkOutput("final_frame_err_count", fe_cnt, exp_fe);
        checkOutput("final_overrun_count", ov_cnt, exp_ov);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
